// File: rtl/uart_rx_fifo_gen.sv
// UART receiver (oversampled, bit-centre sampling) feeding a first-word-fall-through FIFO.
// Each entry is {perr, ferr, data}. The read side also provides a level, almost-flags and an overrun count.
module uart_rx_fifo_gen #(
    parameter int unsigned CLK_HZ     = 48_000_000,
    parameter int unsigned BAUD       = 115_200,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY     = 0,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned AFULL_LVL  = 12,
    parameter int unsigned AEMPTY_LVL = 2,
    parameter int unsigned DROP_ERR   = 0
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        uart_rx,
    input  logic                        rd_en,
    output logic [DATA_BITS-1:0]        dout,
    output logic                        dout_ferr,
    output logic                        dout_perr,
    output logic                        empty,
    output logic                        full,
    output logic                        almost_empty,
    output logic                        almost_full,
    output logic [$clog2(FIFO_DEPTH):0] level,
    output logic [15:0]                 overrun_cnt,
    input  logic                        clr_overrun,
    output logic                        rx_busy
);

    localparam int unsigned TickDen = BAUD * OVERSAMPLE;
    localparam int unsigned DivRaw  = (CLK_HZ + TickDen / 2) / TickDen;
    localparam int unsigned Div     = (DivRaw < 1) ? 1 : DivRaw;
    localparam int unsigned DivW    = (Div > 1) ? $clog2(Div) : 1;
    localparam int unsigned OsW     = $clog2(OVERSAMPLE);
    localparam int unsigned BitW    = $clog2(DATA_BITS + 1);
    localparam int unsigned PtrW    = $clog2(FIFO_DEPTH);
    localparam int unsigned LvlW    = PtrW + 1;
    localparam int unsigned EntW    = DATA_BITS + 2;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop,
        StPush,
        StWaitHigh
    } state_e;

    // ---------------------------------------------------------------------------------------
    // Input synchroniser and edge history
    // ---------------------------------------------------------------------------------------
    logic       rx_s1_q, rx_s2_q, rx_prev_q;
    logic [1:0] init_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_s1_q   <= 1'b1;
            rx_s2_q   <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_s1_q   <= uart_rx;
            rx_s2_q   <= rx_s1_q;
            rx_prev_q <= rx_s2_q;
        end
    end

    // Counts the edges after reset until the synchroniser and the edge history hold real line values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            init_q <= 2'd0;
        end else if (init_q != 2'd3) begin
            init_q <= init_q + 2'd1;
        end
    end

    // ---------------------------------------------------------------------------------------
    // Receive FSM
    // ---------------------------------------------------------------------------------------
    state_e               state_q, state_d;
    logic [DivW-1:0]      div_q, div_d;
    logic [OsW-1:0]       os_q, os_d;
    logic [BitW-1:0]      bit_q, bit_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 ferr_q, ferr_d;
    logic                 perr_q, perr_d;
    logic                 tick, mid, push_req;

    assign tick = (div_q == DivW'(Div - 1));
    assign mid  = tick && (os_q == OsW'(OVERSAMPLE - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            div_q   <= '0;
            os_q    <= '0;
            bit_q   <= '0;
            data_q  <= '0;
            ferr_q  <= 1'b0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            os_q    <= os_d;
            bit_q   <= bit_d;
            data_q  <= data_d;
            ferr_q  <= ferr_d;
            perr_q  <= perr_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        div_d    = tick ? '0 : div_q + 1'b1;
        os_d     = tick ? os_q + 1'b1 : os_q;
        bit_d    = bit_q;
        data_d   = data_q;
        ferr_d   = ferr_q;
        perr_d   = perr_q;
        push_req = 1'b0;

        unique case (state_q)
            StIdle: begin
                os_d = '0;
                // A line already low when the synchroniser becomes valid is a frame in progress.
                if (init_q == 2'd2 && !rx_s2_q) begin
                    state_d = StWaitHigh;
                end else if (init_q == 2'd3 && rx_prev_q && !rx_s2_q) begin
                    state_d = StStart;
                    div_d   = '0;
                    bit_d   = '0;
                    ferr_d  = 1'b0;
                    perr_d  = 1'b0;
                end
            end
            StStart: begin
                if (tick && os_q == OsW'(OVERSAMPLE / 2 - 1)) begin
                    os_d    = '0;
                    state_d = rx_s2_q ? StIdle : StData;
                end
            end
            StData: begin
                if (mid) begin
                    os_d   = '0;
                    data_d = {rx_s2_q, data_q[DATA_BITS-1:1]};
                    if (bit_q == BitW'(DATA_BITS - 1)) begin
                        bit_d   = '0;
                        state_d = (PARITY != 0) ? StParity : StStop;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            StParity: begin
                if (mid) begin
                    os_d    = '0;
                    perr_d  = (^data_q) ^ rx_s2_q ^ (PARITY == 1);
                    state_d = StStop;
                end
            end
            StStop: begin
                if (mid) begin
                    os_d = '0;
                    if (!rx_s2_q) begin
                        ferr_d = 1'b1;
                    end
                    if (bit_q == BitW'(STOP_BITS - 1)) begin
                        bit_d   = '0;
                        state_d = StPush;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            StPush: begin
                push_req = 1'b1;
                // Break: hold off until the line returns high so the low level is not a new start.
                state_d  = (ferr_q && data_q == '0) ? StWaitHigh : StIdle;
            end
            StWaitHigh: begin
                if (rx_s2_q) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign rx_busy = (state_q != StIdle);

    // ---------------------------------------------------------------------------------------
    // FIFO
    // ---------------------------------------------------------------------------------------
    logic [EntW-1:0] mem_q [FIFO_DEPTH];
    logic [EntW-1:0] head;
    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [LvlW-1:0] level_q, level_d;
    logic [15:0]     ovr_q;
    logic            drop, do_pop, accept, do_push, lost;

    assign drop    = (DROP_ERR != 0) && (ferr_q || perr_q);
    assign do_pop  = rd_en && !empty;
    assign accept  = !full || do_pop;
    assign do_push = push_req && !drop && accept;
    assign lost    = push_req && !drop && !accept;

    always_comb begin
        level_d = level_q;
        if (do_push && !do_pop) begin
            level_d = level_q + 1'b1;
        end else if (do_pop && !do_push) begin
            level_d = level_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            level_q <= level_d;
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= {perr_q, ferr_q, data_q};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovr_q <= '0;
        end else if (clr_overrun) begin
            ovr_q <= '0;
        end else if (lost && ovr_q != 16'hFFFF) begin
            ovr_q <= ovr_q + 16'd1;
        end
    end

    assign head         = mem_q[rd_ptr_q];
    assign empty        = (level_q == '0);
    assign full         = (level_q == LvlW'(FIFO_DEPTH));
    assign almost_empty = (level_q <= LvlW'(AEMPTY_LVL));
    assign almost_full  = (level_q >= LvlW'(AFULL_LVL));
    assign level        = level_q;
    assign overrun_cnt  = ovr_q;
    assign dout         = empty ? '0 : head[DATA_BITS-1:0];
    assign dout_ferr    = !empty && head[DATA_BITS];
    assign dout_perr    = !empty && head[DATA_BITS+1];

endmodule

// File: tb/tb_uart_rx_fifo_gen.sv
// Scoreboard bench for uart_rx_fifo_gen. Three instances cover no parity, even parity with two
// stop bits, and error dropping. Frames are built bit by bit and the expected FIFO is kept as queues.
`timescale 1ns/1ps
module tb_uart_rx_fifo_gen;

    localparam int NI    = 3;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [NI-1:0] rst_n_v, rx_v, rd_v, clr_v;
    logic [7:0]    dout_v [NI];
    logic [NI-1:0] ferr_v, perr_v, empty_v, full_v, aempty_v, afull_v, busy_v;
    logic [2:0]    level_v [NI];
    logic [15:0]   ovr_v [NI];

    int          errors = 0;
    int          checks = 0;
    logic [9:0]  mq [NI][$];
    int unsigned movr [NI];
    logic [9:0]  mon_e;

    uart_rx_fifo_gen #(
        .CLK_HZ(1_600_000), .BAUD(100_000), .OVERSAMPLE(16), .DATA_BITS(8), .PARITY(0),
        .STOP_BITS(1), .FIFO_DEPTH(DEPTH), .AFULL_LVL(3), .AEMPTY_LVL(1), .DROP_ERR(0)
    ) u0 (
        .clk(clk), .rst_n(rst_n_v[0]), .uart_rx(rx_v[0]), .rd_en(rd_v[0]), .dout(dout_v[0]),
        .dout_ferr(ferr_v[0]), .dout_perr(perr_v[0]), .empty(empty_v[0]), .full(full_v[0]),
        .almost_empty(aempty_v[0]), .almost_full(afull_v[0]), .level(level_v[0]),
        .overrun_cnt(ovr_v[0]), .clr_overrun(clr_v[0]), .rx_busy(busy_v[0])
    );

    uart_rx_fifo_gen #(
        .CLK_HZ(1_600_000), .BAUD(100_000), .OVERSAMPLE(16), .DATA_BITS(8), .PARITY(2),
        .STOP_BITS(2), .FIFO_DEPTH(DEPTH), .AFULL_LVL(2), .AEMPTY_LVL(2), .DROP_ERR(0)
    ) u1 (
        .clk(clk), .rst_n(rst_n_v[1]), .uart_rx(rx_v[1]), .rd_en(rd_v[1]), .dout(dout_v[1]),
        .dout_ferr(ferr_v[1]), .dout_perr(perr_v[1]), .empty(empty_v[1]), .full(full_v[1]),
        .almost_empty(aempty_v[1]), .almost_full(afull_v[1]), .level(level_v[1]),
        .overrun_cnt(ovr_v[1]), .clr_overrun(clr_v[1]), .rx_busy(busy_v[1])
    );

    uart_rx_fifo_gen #(
        .CLK_HZ(1_600_000), .BAUD(100_000), .OVERSAMPLE(16), .DATA_BITS(8), .PARITY(2),
        .STOP_BITS(1), .FIFO_DEPTH(DEPTH), .AFULL_LVL(3), .AEMPTY_LVL(1), .DROP_ERR(1)
    ) u2 (
        .clk(clk), .rst_n(rst_n_v[2]), .uart_rx(rx_v[2]), .rd_en(rd_v[2]), .dout(dout_v[2]),
        .dout_ferr(ferr_v[2]), .dout_perr(perr_v[2]), .empty(empty_v[2]), .full(full_v[2]),
        .almost_empty(aempty_v[2]), .almost_full(afull_v[2]), .level(level_v[2]),
        .overrun_cnt(ovr_v[2]), .clr_overrun(clr_v[2]), .rx_busy(busy_v[2])
    );

    function automatic int par_of(input int i);
        return (i == 0) ? 0 : 2;
    endfunction
    function automatic int stop_of(input int i);
        return (i == 1) ? 2 : 1;
    endfunction
    function automatic bit drop_of(input int i);
        return (i == 2);
    endfunction
    function automatic int afull_of(input int i);
        return (i == 1) ? 2 : 3;
    endfunction
    function automatic int aempty_of(input int i);
        return (i == 1) ? 2 : 1;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every accepted pop request is checked against the head of the model queue.
    always @(negedge clk) begin
        for (int i = 0; i < NI; i++) begin
            if (rd_v[i] && rst_n_v[i]) begin
                if (mq[i].size() == 0) begin
                    check($sformatf("pop_empty[%0d]", i), 32'(empty_v[i]), 32'd1);
                end else begin
                    mon_e = mq[i].pop_front();
                    check($sformatf("pop_entry[%0d]", i),
                          32'({empty_v[i], perr_v[i], ferr_v[i], dout_v[i]}), 32'({1'b0, mon_e}));
                end
            end
        end
    end

    task automatic chk_status(input int i, input string tag);
        int         n;
        logic [9:0] h;
        @(negedge clk);
        n = mq[i].size();
        h = (n > 0) ? mq[i][0] : 10'd0;
        check($sformatf("%s level[%0d]", tag, i), 32'(level_v[i]), 32'(n));
        check($sformatf("%s flags[%0d]", tag, i),
              32'({empty_v[i], full_v[i], aempty_v[i], afull_v[i]}),
              32'({n == 0, n == DEPTH, n <= aempty_of(i), n >= afull_of(i)}));
        check($sformatf("%s overrun[%0d]", tag, i), 32'(ovr_v[i]), 32'(movr[i]));
        check($sformatf("%s head[%0d]", tag, i), 32'({perr_v[i], ferr_v[i], dout_v[i]}), 32'(h));
    endtask

    task automatic send_frame(input int i, input logic [7:0] d, input bit bad_par,
                              input bit bad_stop, input int low_after, input int gap);
        logic bits [$];
        logic pbit;
        bit   perr, ferr;
        bits.push_back(1'b0);
        for (int b = 0; b < 8; b++) bits.push_back(d[b]);
        if (par_of(i) != 0) begin
            pbit = (par_of(i) == 2) ? ^d : ~^d;
            bits.push_back(bad_par ? ~pbit : pbit);
        end
        for (int s = 0; s < stop_of(i); s++) bits.push_back(!(bad_stop && s == stop_of(i) - 1));
        @(posedge clk);
        #1;
        foreach (bits[b]) begin
            rx_v[i] = bits[b];
            repeat (16) @(posedge clk);
            #1;
        end
        perr = (par_of(i) != 0) && bad_par;
        ferr = bad_stop;
        if (!(drop_of(i) && (perr || ferr))) begin
            if (mq[i].size() < DEPTH) mq[i].push_back({perr, ferr, d});
            else if (movr[i] != 32'hFFFF) movr[i]++;
        end
        if (low_after > 0) begin
            rx_v[i] = 1'b0;
            repeat (low_after * 8) @(posedge clk);
            @(negedge clk);
            check($sformatf("busy_low[%0d]", i), 32'(busy_v[i]), 32'(ferr && d == 8'h00));
            repeat (low_after * 8) @(posedge clk);
            #1;
        end
        rx_v[i] = 1'b1;
        repeat (gap * 16) @(posedge clk);
        @(negedge clk);
        check($sformatf("busy_idle[%0d]", i), 32'(busy_v[i]), 32'd0);
    endtask

    task automatic pop(input int i);
        @(posedge clk);
        #1 rd_v[i] = 1'b1;
        @(posedge clk);
        #1 rd_v[i] = 1'b0;
    endtask

    task automatic send_ok(input int i, input logic [7:0] d);
        send_frame(i, d, 1'b0, 1'b0, 0, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst_n_v = '0;
        rx_v    = '1;
        rd_v    = '0;
        clr_v   = '0;
        for (int i = 0; i < NI; i++) movr[i] = 0;
        repeat (3) @(posedge clk);
        for (int i = 0; i < NI; i++) chk_status(i, "reset");
        @(posedge clk);
        #1 rst_n_v = '1;
        repeat (5) @(posedge clk);

        // Two bytes, FWFT head, empty latency after PUSH, drain and pop on empty.
        fork
            send_ok(0, 8'hA5);
            begin
                @(posedge clk);
                repeat (155) @(posedge clk);
                @(negedge clk);
                check("empty_in_push", 32'(empty_v[0]), 32'd1);
                @(negedge clk);
                check("empty_after_push", 32'(empty_v[0]), 32'd0);
            end
        join
        send_ok(0, 8'h3C);
        chk_status(0, "t1_two");
        pop(0);
        chk_status(0, "t1_one");
        pop(0);
        chk_status(0, "t1_empty");
        pop(0);
        chk_status(0, "t1_underflow");

        // Parity error stored, then dropped on the error-dropping instance.
        send_frame(1, 8'h07, 1'b1, 1'b0, 0, 1);
        chk_status(1, "t2_perr");
        send_ok(1, 8'h07);
        pop(1);
        pop(1);
        chk_status(1, "t2_drained");
        send_frame(2, 8'h07, 1'b1, 1'b0, 0, 1);
        send_frame(2, 8'h5A, 1'b0, 1'b1, 0, 1);
        chk_status(2, "t2_dropped");
        send_ok(2, 8'h81);
        pop(2);

        // Stop-bit error, break with long low, then a clean byte.
        send_frame(0, 8'h55, 1'b0, 1'b1, 3, 1);
        send_frame(0, 8'h00, 1'b0, 1'b1, 5, 1);
        send_ok(0, 8'h12);
        chk_status(0, "t3_break");
        repeat (3) pop(0);

        // Overflow with saturating counter, read-back order, clear.
        for (int b = 1; b <= 6; b++) send_ok(0, 8'(b));
        chk_status(0, "t4_full");
        repeat (4) pop(0);
        @(posedge clk);
        #1 clr_v[0] = 1'b1;
        @(posedge clk);
        #1 clr_v[0] = 1'b0;
        movr[0] = 0;
        chk_status(0, "t4_clr");

        // Full FIFO with a pop in the PUSH cycle: write accepted, nothing lost.
        send_ok(0, 8'h11);
        send_ok(0, 8'h22);
        send_ok(0, 8'h33);
        send_ok(0, 8'h44);
        fork
            send_ok(0, 8'h77);
            begin
                @(posedge clk);
                repeat (155) @(posedge clk);
                #1 rd_v[0] = 1'b1;
                @(posedge clk);
                #1 rd_v[0] = 1'b0;
            end
        join
        chk_status(0, "t5_pop_push");
        repeat (4) pop(0);
        chk_status(0, "t5_drained");

        // Glitch shorter than half a bit: false start.
        @(posedge clk);
        #1 rx_v[0] = 1'b0;
        repeat (4) @(posedge clk);
        #1 rx_v[0] = 1'b1;
        repeat (6) @(posedge clk);
        @(negedge clk);
        check("glitch_busy_end", 32'(busy_v[0]), 32'd1);
        @(negedge clk);
        check("glitch_busy_idle", 32'(busy_v[0]), 32'd0);
        chk_status(0, "t6_glitch");

        // Asynchronous reset mid-DATA with three entries stored, released with the line low.
        send_ok(0, 8'hC1);
        send_ok(0, 8'hC2);
        send_ok(0, 8'hC3);
        @(posedge clk);
        #1 rx_v[0] = 1'b0;
        repeat (40) @(posedge clk);
        #3 rst_n_v[0] = 1'b0;
        #1;
        check("async_rst_level", 32'(level_v[0]), 32'd0);
        check("async_rst_flags", 32'({empty_v[0], busy_v[0], dout_v[0]}), 32'h200);
        mq[0].delete();
        movr[0] = 0;
        @(posedge clk);
        #1 rst_n_v[0] = 1'b1;
        repeat (6) @(posedge clk);
        @(negedge clk);
        check("rst_low_wait", 32'(busy_v[0]), 32'd1);
        rx_v[0] = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("rst_low_release", 32'(busy_v[0]), 32'd0);
        chk_status(0, "t6_after_rst");
        send_ok(0, 8'h9C);
        chk_status(0, "t6_9c");
        pop(0);

        // Randomised frames, errors and pops against the queue model.
        for (int i = 0; i < NI; i++) begin
            for (int n = 0; n < 25; n++) begin
                logic [7:0] d;
                bit         bp, bs;
                int         la;
                d  = 8'($urandom);
                bp = (par_of(i) != 0) && ($urandom_range(0, 4) == 0);
                bs = ($urandom_range(0, 5) == 0);
                la = (bs && $urandom_range(0, 1) == 1) ? int'($urandom_range(1, 3)) : 0;
                send_frame(i, d, bp, bs, la, int'($urandom_range(1, 2)));
                repeat ($urandom_range(0, 2)) pop(i);
                if (n % 5 == 4) chk_status(i, "rand");
            end
            repeat (DEPTH) pop(i);
            chk_status(i, "rand_end");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo_gen.md
Name: uart_rx_fifo_gen

Overview:
Parametrised UART receiver with an inferred, vendor-independent synchronous FIFO. It has configurable data width, parity and stop bits, and stores frame and parity error flags alongside each entry. The read side is first-word-fall-through, with occupancy level, almost-flags and a saturating overrun counter. It is a drop-in successor for the board-level UART RX path; the host logic pops bytes on the clk domain.

Parameters:
CLK_HZ, 48_000_000, system clock frequency in Hz
BAUD, 115_200, line baud rate
OVERSAMPLE, 16, ticks per bit; must be even and >= 8
DATA_BITS, 8, data bits per frame, 5..9
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, 1 or 2
FIFO_DEPTH, 16, number of entries; power of 2, >= 4
AFULL_LVL, 12, almost_full asserts when level >= AFULL_LVL
AEMPTY_LVL, 2, almost_empty asserts when level <= AEMPTY_LVL
DROP_ERR, 0, 1 = frames with ferr or perr are discarded and not written

Ports:
clk  in  1  system clock; all logic is on rising edge
rst_n  in  1  asynchronous active-low reset
uart_rx  in  1  asynchronous serial input, idle high
rd_en  in  1  pop request; ignored when empty
dout  out  DATA_BITS  head entry data; valid while !empty; 0 when empty
dout_ferr  out  1  head entry stop-bit error; 0 when empty
dout_perr  out  1  head entry parity error; 0 when empty (always 0 if PARITY = 0)
empty  out  1  level == 0
full  out  1  level == FIFO_DEPTH
almost_empty  out  1  level <= AEMPTY_LVL
almost_full  out  1  level >= AFULL_LVL
level  out  $clog2(FIFO_DEPTH)+1  current occupancy
overrun_cnt  out  16  count of frames lost to full; saturates at 16'hFFFF
clr_overrun  in  1  synchronous clear of overrun_cnt; takes priority over increment
rx_busy  out  1  high whenever the FSM is not in IDLE

Behaviour:
- Reset values: FSM IDLE, FIFO pointers and level 0, empty = 1, almost_empty = 1, full = 0, almost_full = 0, overrun_cnt = 0, rx_busy = 0, dout/dout_ferr/dout_perr = 0. The memory array is not reset.
- Input path: uart_rx passes through a 2-FF synchroniser (both stages reset to 1). The tick divider is DIV = round(CLK_HZ / (BAUD * OVERSAMPLE)), min 1. The tick counter restarts on start-edge detection.
- FSM states: IDLE, START, DATA, PARITY, STOP, PUSH, WAIT_HIGH.
  - IDLE -> START on a synced falling edge (previous 1, current 0).
  - START: at OVERSAMPLE/2 ticks, sample the line. If 1, this is a false start -> IDLE. If 0 -> DATA.
  - DATA: sample every OVERSAMPLE ticks (bit centre), LSB first, for DATA_BITS bits. Then -> PARITY if PARITY != 0, else -> STOP.
  - PARITY: sample the parity bit. perr = 1 if the parity does not match the odd/even setting.
  - STOP: sample STOP_BITS bits. ferr = 1 if any sampled stop bit is 0. After the last stop sample -> PUSH. The FSM does not wait for the end of the stop bit.
  - PUSH: one cycle; issues the write request. If ferr = 1 and all data bits are 0 (break condition) -> WAIT_HIGH, else -> IDLE.
  - WAIT_HIGH: stay until the synced line is 1, then -> IDLE.
- After reset release, if the synced line is 0, the FSM enters WAIT_HIGH first so no mid-frame capture occurs.
- Entry format: {perr, ferr, data}, DATA_BITS + 2 bits wide.
- Write rule (in PUSH):
  - If DROP_ERR = 1 and (ferr | perr): discard; no write and no overrun count.
  - Else the write is accepted if !full, or if rd_en is high while !empty in the same cycle (simultaneous pop).
  - Else the frame is dropped and overrun_cnt increments, saturating.
- FIFO: pointers are $clog2(FIFO_DEPTH) bits and wrap naturally. level updates on the clock edge: +1 for push only, -1 for pop only, unchanged for push+pop. Flags decode combinationally from the level register.
- Read side (FWFT): dout shows the entry at rd_ptr whenever !empty. A pop with rd_en advances rd_ptr and the next entry appears the following cycle. rd_en while empty has no effect: level does not underflow and pointers do not move.
- Latency: empty deasserts 1 cycle after the PUSH cycle. The PUSH cycle occurs 1 clk after the last stop-bit centre sample.
- Reset mid-frame or with data in the FIFO: everything returns to reset values immediately (asynchronous); partial frames and stored entries are lost.

Test Plan:
All scenarios use CLK_HZ = 1_600_000, BAUD = 100_000, OVERSAMPLE = 16 (DIV = 1, 16 clk per bit).
1. Defaults, send 0xA5 then 0x3C, no pops -> level = 2, dout = 0xA5 with ferr = 0 and perr = 0. After one rd_en, dout = 0x3C; after a second rd_en, empty = 1 and dout = 0.
2. PARITY = 2 (even), send 0x07 with parity bit 0 (wrong) -> entry shows perr = 1. Repeat with DROP_ERR = 1 -> level stays 0 and overrun_cnt = 0.
3. Send 0x55 with the stop bit forced low, then hold the line low for 3 bit times -> ferr = 1 entry. Then send 0x00 with the line held low for 5 bit times, then release and send 0x12 -> the 0x00 frame is stored as a break (ferr = 1), the FSM sits in WAIT_HIGH until release, and exactly 0x12 is stored after it.
4. FIFO_DEPTH = 4: send 6 bytes 0x01..0x06 with no pops -> full = 1, level = 4, overrun_cnt = 2, and entries read back as 0x01..0x04. Then pulse clr_overrun -> overrun_cnt = 0.
5. FIFO full and rd_en high during the PUSH cycle of byte 0x77 -> push accepted, level stays 4, overrun_cnt unchanged, and 0x77 is read back last.
6. Line glitches low for 4 clk, then a second case asserts rst_n low mid-DATA while level = 3 -> the glitch produces no entry and rx_busy returns to 0 after 8 clk. The reset clears the FIFO (level = 0, empty = 1), and the next clean 0x9C is received correctly.
